// File: rtl/zx_dma_pkg.sv
// Shared definitions for the ZX DMA read/write engine: register map,
// control/status bit positions and engine state encoding.
package zx_dma_pkg;

    // Register select codes
    localparam logic [1:0] RS_HAD = 2'b00;   // address bits [AW-1:16]
    localparam logic [1:0] RS_MAD = 2'b01;   // address bits [15:8]
    localparam logic [1:0] RS_LAD = 2'b10;   // address bits [7:0]
    localparam logic [1:0] RS_CST = 2'b11;   // control / status

    // Control/status bit positions
    localparam int unsigned CST_ON   = 7;
    localparam int unsigned CST_DIR  = 6;
    localparam int unsigned CST_BUSY = 0;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/zx_strobe_sync.sv
// Brings an asynchronous ZX strobe into the clk domain and produces
// one-cycle begin (rising) and end (falling) pulses.
module zx_strobe_sync #(
    parameter int unsigned SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_begin,
    output logic o_end
);

    logic [SYNC:0] r_sync;

    // Shift the raw strobe through SYNC+1 flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC-1:0], i_strobe};
        end
    end

    // Edges are decoded from the last two stages only
    assign o_begin = r_sync[SYNC-1] & ~r_sync[SYNC];
    assign o_end   = ~r_sync[SYNC-1] & r_sync[SYNC];

endmodule

// File: rtl/zx_dma_rw.sv
// ZX-bus DMA engine: moves single bytes between the ZX DMA strobes and a
// memory arbiter, with a one-byte read prefetch buffer and a one-deep
// write pend that stalls the Z80 through wait_ena.
module zx_dma_rw
    import zx_dma_pkg::*;
#(
    parameter int unsigned AW   = 21,
    parameter int unsigned SYNC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          zxdmaread,
    input  logic          zxdmawrite,
    input  logic [7:0]    dma_wr_data,
    output logic [7:0]    dma_rd_data,
    output logic          wait_ena,
    output logic          dma_on,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    input  logic          module_select,
    input  logic          write_strobe,
    input  logic [1:0]    regsel,
    output logic [AW-1:0] dma_addr,
    output logic [7:0]    dma_wd,
    input  logic [7:0]    dma_rd,
    output logic          dma_rnw,
    output logic          dma_req,
    input  logic          dma_ack,
    input  logic          dma_end
);

    localparam int unsigned HW = AW - 16;

    state_t        r_state;
    logic          r_req;
    logic          r_dma_on;
    logic          r_dir;
    logic [AW-1:0] r_addr;
    logic          r_wait;
    logic [7:0]    r_rd_data;
    logic [7:0]    r_wd;
    logic [7:0]    r_buf;
    logic          r_bvalid;
    logic          r_pend;

    logic w_rd_begin;
    logic w_rd_end;
    logic w_wr_begin;
    logic w_wr_end;
    logic w_unused_ends;
    logic w_cfg_wr;
    logic w_cst_wr;
    logic w_en;
    logic w_ack;
    logic w_end;
    logic w_launch;
    logic w_relaunch;
    logic w_busy;

    zx_strobe_sync #(.SYNC(SYNC)) u_rd_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (zxdmaread),
        .o_begin  (w_rd_begin),
        .o_end    (w_rd_end)
    );

    zx_strobe_sync #(.SYNC(SYNC)) u_wr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (zxdmawrite),
        .o_begin  (w_wr_begin),
        .o_end    (w_wr_end)
    );

    // Trailing strobe edges carry no meaning for this engine
    assign w_unused_ends = w_rd_end | w_wr_end;

    assign w_cfg_wr = module_select & write_strobe;
    assign w_cst_wr = w_cfg_wr & (regsel == RS_CST);
    // Engine is treated as disabled already in the cycle it is switched off,
    // so every flag clears on the same edge that drops dma_on
    assign w_en     = r_dma_on & ~(w_cst_wr & ~din[CST_ON]);
    assign w_ack    = (r_state == ST_REQ) & dma_ack;
    assign w_end    = (r_state == ST_XFER) & dma_end;
    assign w_busy   = (r_state != ST_IDLE) | r_pend;

    // Read mode prefetches whenever the buffer is empty; write mode launches on a ZX write
    assign w_launch   = w_en & (r_dir ? w_wr_begin : ~r_bvalid);
    // Back-to-back write: pended data, or a write arriving with the completion
    assign w_relaunch = w_en & r_dir & (r_pend | w_wr_begin);

    // Configuration registers and address counter; the ack increment wins over a CPU write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dma_on <= 1'b0;
            r_dir    <= 1'b0;
            r_addr   <= '0;
        end else begin
            if (w_cfg_wr) begin
                case (regsel)
                    RS_HAD: if (!w_ack) r_addr[AW-1:16] <= din[HW-1:0];
                    RS_MAD: if (!w_ack) r_addr[15:8]    <= din;
                    RS_LAD: if (!w_ack) r_addr[7:0]     <= din;
                    RS_CST: begin
                        r_dma_on <= din[CST_ON];
                        if (!r_dma_on) begin
                            r_dir <= din[CST_DIR];
                        end
                    end
                    default: ;
                endcase
            end
            if (w_ack) begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    // Arbiter handshake FSM with registered request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dma_ack) begin
                        r_state <= ST_XFER;
                        r_req   <= 1'b0;
                    end else if (!w_en) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (dma_end) begin
                        if (w_relaunch) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Data path: read buffer, stall handling and write pend.
    // A completion coinciding with a strobe is applied first, then the strobe,
    // which is why those cases never raise wait_ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= 1'b0;
            r_rd_data <= '0;
            r_wd      <= '0;
            r_buf     <= '0;
            r_bvalid  <= 1'b0;
            r_pend    <= 1'b0;
        end else if (!w_en) begin
            r_wait   <= 1'b0;
            r_bvalid <= 1'b0;
            r_pend   <= 1'b0;
        end else if (!r_dir) begin
            if (w_end) begin
                if (r_wait) begin
                    r_rd_data <= dma_rd;
                    r_wait    <= 1'b0;
                end else if (w_rd_begin) begin
                    r_buf     <= dma_rd;
                    r_rd_data <= dma_rd;
                end else begin
                    r_buf    <= dma_rd;
                    r_bvalid <= 1'b1;
                end
            end else if (w_rd_begin) begin
                if (r_bvalid) begin
                    r_rd_data <= r_buf;
                    r_bvalid  <= 1'b0;
                end else begin
                    r_wait <= 1'b1;
                end
            end
        end else begin
            if (w_end) begin
                if (r_pend) begin
                    r_wd   <= dma_wr_data;
                    r_pend <= 1'b0;
                    r_wait <= 1'b0;
                end else if (w_wr_begin) begin
                    r_wd <= dma_wr_data;
                end
            end else if (w_wr_begin) begin
                if (r_state == ST_IDLE) begin
                    r_wd <= dma_wr_data;
                end else begin
                    r_pend <= 1'b1;
                    r_wait <= 1'b1;
                end
            end
        end
    end

    // Register read-back mux
    always_comb begin
        dout = '0;
        case (regsel)
            RS_HAD: dout[HW-1:0] = r_addr[AW-1:16];
            RS_MAD: dout         = r_addr[15:8];
            RS_LAD: dout         = r_addr[7:0];
            RS_CST: begin
                dout[CST_ON]   = r_dma_on;
                dout[CST_DIR]  = r_dir;
                dout[CST_BUSY] = w_busy;
            end
            default: dout = '0;
        endcase
    end

    assign dma_rd_data = r_rd_data;
    assign wait_ena    = r_wait;
    assign dma_on      = r_dma_on;
    assign dma_addr    = r_addr;
    assign dma_wd      = r_wd;
    assign dma_rnw     = ~r_dir;
    assign dma_req     = r_req;

endmodule

// File: doc/zx_dma_rw.md
ZX_DMA_RW -- requirements
Module: zx_dma_rw

Interface
REQ-001 SHALL have parameter AW, default 21: DMA address width, 17..24.
REQ-002 SHALL have parameter SYNC, default 2: ZX strobe synchroniser depth, minimum 2.
REQ-003 SHALL have port clk, input, 1: system clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports zxdmaread / zxdmawrite, input, 1 each: asynchronous ZX bus DMA strobes.
REQ-006 SHALL have port dma_wr_data, input, 8: ZX write data. Port dma_rd_data, output, 8: ZX read data.
REQ-007 SHALL have port wait_ena, output, 1: stall ZX Z80.
REQ-008 SHALL have port dma_on, output, 1: engine enabled.
REQ-009 SHALL have ports din / dout, input / output, 8 each: ports.v data.
REQ-010 SHALL have ports module_select, write_strobe, input, 1 each, and regsel, input, 2: register access.
REQ-011 SHALL have ports dma_addr, output, AW; dma_wd, output, 8; dma_rd, input, 8; dma_rnw, output, 1.
REQ-012 SHALL have ports dma_req, output, 1; dma_ack, input, 1; dma_end, input, 1: arbiter handshake.

Function
REQ-013 SHALL decode regsel as follows:
- 00: dma_addr[AW-1:16], zero-extended on read.
- 01: dma_addr[15:8].
- 10: dma_addr[7:0].
- 11: control/status = {dma_on, dir, 5'b0, busy}. busy = FSM not IDLE, or pend.
REQ-014 SHALL update a register on module_select && write_strobe; CST write sets dma_on=din[7]; dir=din[6] only when dma_on was 0.
REQ-015 SHALL drive dma_rnw = ~dir as a constant for the whole session.
REQ-016 SHALL synchronise each strobe through SYNC+1 flops; begin/end pulses are one cycle wide, decoded from the last two stages.
REQ-017 SHALL ignore strobes opposite to dir, and all strobes while dma_on=0.
REQ-018 SHALL implement FSM states IDLE, REQ and XFER:
- IDLE->REQ on a launch.
- REQ->XFER on dma_ack.
- XFER->IDLE on dma_end.
REQ-019 SHALL drive dma_req high exactly while the state is REQ, registered; it SHALL assert the cycle after launch.
REQ-020 SHALL increment dma_addr by 1, modulo 2^AW, in the dma_ack cycle; this takes priority over a simultaneous address-register write, which is dropped.
REQ-021 Read mode (dir=0) SHALL keep a one-byte buffer buf with flag bvalid.
- Launch occurs when IDLE && !bvalid && no pending fetch.
- At dma_end: buf<=dma_rd and bvalid<=1, unless a stalled read is waiting.
REQ-022 Read mode, on read_begin:
- bvalid=1: dma_rd_data<=buf, bvalid<=0.
- bvalid=0: wait_ena<=1; at dma_end, dma_rd_data<=dma_rd and wait_ena<=0 in the same cycle, and bvalid stays 0.
REQ-023 Write mode (dir=1), on write_begin:
- IDLE: dma_wd<=dma_wr_data, then launch.
- Otherwise: pend<=1, wait_ena<=1.
REQ-024 Write mode, at dma_end with pend=1: dma_wd<=dma_wr_data, relaunch, pend<=0, wait_ena<=0, all in the same cycle.
REQ-025 A dma_end coinciding with a read_begin/write_begin SHALL be handled as completion first, then the strobe; no stall is generated.
REQ-026 dma_on cleared mid-operation SHALL:
- force dma_req, wait_ena, bvalid and pend to 0 next cycle;
- leave XFER waiting for dma_end, discarding its data;
- from REQ, return to IDLE immediately.
REQ-027 dma_rd_data, buf and dma_wd SHALL hold their values when not updated.

Reset
REQ-028 On rst_n low, all of the following SHALL be 0: dma_on, dir, dma_addr, dma_req, wait_ena, dma_rd_data, dma_wd, bvalid, pend, and the synchroniser flops; the FSM SHALL be IDLE.
REQ-029 dout SHALL be combinational and SHALL reflect reset register values.

Structure
REQ-030 Package zx_dma_pkg SHALL hold the regsel codes, the CST bit positions (ON=7, DIR=6, BUSY=0) and the FSM state encoding.
REQ-031 Sub-module zx_strobe_sync (parameter SYNC; outputs begin/end pulses) SHALL be instantiated twice.

Verification
REQ-032 Read prefetch: write addr 0x01_2345, CST=0x80; ack after 2 cycles, dma_end returns 0xA5.
- Expect dma_addr=0x012346 and bvalid=1.
- ZX read then yields dma_rd_data=0xA5 with no wait_ena, and a second fetch is launched.
REQ-033 Read stall: ZX read arrives before the first dma_end.
- Expect wait_ena=1 until dma_end(0x3C).
- wait_ena drops in the same cycle dma_rd_data=0x3C.
REQ-034 Write back-to-back: CST=0xC0; two ZX writes 0x11, 0x22 with the second during XFER.
- Expect wait_ena=1 during the second write.
- Expect dma_wd=0x22 on relaunch and dma_rnw=0 throughout.
REQ-035 Wrap/priority: AW=21, addr 0x1F_FFFF; dma_ack coincides with an LAD write of 0x55.
- Expect addr=0x000000 and the write dropped.
REQ-036 Abort: CST=0x00 written in XFER with wait_ena=1.
- Expect wait_ena=0 and dma_req=0 next cycle.
- Expect busy=1 until dma_end, then 0.
- Expect a dir change accepted afterwards.
